// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary blocks: widths, forward-select
// encodings and architectural register numbers.
package pipe_pkg;

   localparam int ALUC_W = 4;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_EXE  = 2'b01,
      FWD_MALU = 2'b10,
      FWD_MMO  = 2'b11
   } fwd_sel_e;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_W-1:0] REG_RA   = 5'd31;

   // A writing stage matches a source only for a nonzero destination.
   function automatic logic reg_hit(input logic wr, input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
      return wr & (dst != REG_ZERO) & (dst == src);
   endfunction

endpackage

// File: rtl/pipe_idexe_reg_fwd_sel.sv
// Operand forwarding for one ID-stage source: EXE result beats MEM result,
// which beats the register-file value.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0]  src,
   input  logic [DATA_W-1:0] rfval,
   input  logic              ewreg,
   input  logic              em2reg,
   input  logic [REG_W-1:0]  ern,
   input  logic [DATA_W-1:0] ealu,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic [REG_W-1:0]  mrn,
   input  logic [DATA_W-1:0] malu,
   input  logic [DATA_W-1:0] mmo,
   output fwd_sel_e          sel,
   output logic [DATA_W-1:0] opnd
);

   logic exe_hit_s;
   logic mem_hit_s;

   // Select the forwarding source; a load in EXE has no result yet, so it never forwards.
   always_comb begin
      sel       = FWD_RF;
      exe_hit_s = reg_hit(ewreg & ~em2reg, ern, src);
      mem_hit_s = reg_hit(mwreg, mrn, src);
      if (exe_hit_s) begin
         sel = FWD_EXE;
      end else if (mem_hit_s) begin
         sel = mm2reg ? FWD_MMO : FWD_MALU;
      end else begin
         sel = FWD_RF;
      end
   end

   // Operand mux driven by the select.
   always_comb begin
      opnd = rfval;
      case (sel)
         FWD_RF:   opnd = rfval;
         FWD_EXE:  opnd = ealu;
         FWD_MALU: opnd = malu;
         FWD_MMO:  opnd = mmo;
         default:  opnd = rfval;
      endcase
   end

endmodule

// File: rtl/pipe_idexe_reg.sv
// ID/EXE pipeline register with operand forwarding, load-use interlock,
// flush bubbles, downstream hold and a bubble counter.
module pipe_idexe_reg
   import pipe_pkg::*;
#(
   parameter int CNTW = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              dwreg,
   input  logic              dm2reg,
   input  logic              dwmem,
   input  logic              djal,
   input  logic              daluimm,
   input  logic              dshift,
   input  logic [ALUC_W-1:0] daluc,
   input  logic [DATA_W-1:0] da,
   input  logic [DATA_W-1:0] db,
   input  logic [DATA_W-1:0] dimm,
   input  logic [DATA_W-1:0] dpc4,
   input  logic [REG_W-1:0]  drs,
   input  logic [REG_W-1:0]  drt,
   input  logic [REG_W-1:0]  drn,
   input  logic              dusers,
   input  logic              duserts,
   input  logic              dflush,
   input  logic              hold,
   input  logic [REG_W-1:0]  ern,
   input  logic [DATA_W-1:0] ealu,
   input  logic [REG_W-1:0]  mrn,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic [DATA_W-1:0] malu,
   input  logic [DATA_W-1:0] mmo,
   output logic              ewreg,
   output logic              em2reg,
   output logic              ewmem,
   output logic              ejal,
   output logic              ealuimm,
   output logic              eshift,
   output logic [ALUC_W-1:0] ealuc,
   output logic [DATA_W-1:0] ea,
   output logic [DATA_W-1:0] eb,
   output logic [DATA_W-1:0] eimm,
   output logic [DATA_W-1:0] epc4,
   output logic [REG_W-1:0]  ern0,
   output logic              evalid,
   output logic              stall,
   output logic [CNTW-1:0]   nbubble
);

   fwd_sel_e          sel_a_s;
   fwd_sel_e          sel_b_s;
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic              luse_s;
   logic              bubble_s;
   logic              unused_s;

   fwd_sel u_fwd_a (
      .src(drs), .rfval(da),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
      .sel(sel_a_s), .opnd(fwd_a_s)
   );

   fwd_sel u_fwd_b (
      .src(drt), .rfval(db),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
      .sel(sel_b_s), .opnd(fwd_b_s)
   );

   assign unused_s = ^{sel_a_s, sel_b_s};

   // Load in EXE whose destination is read by the ID instruction.
   always_comb begin
      luse_s   = (ewreg & em2reg & (ern != REG_ZERO)) &
                 ((dusers & (ern == drs)) | (duserts & (ern == drt)));
      bubble_s = dflush | luse_s;
      stall    = hold | luse_s;
   end

   // E-stage registers: hold freezes everything, a bubble kills side-effecting controls.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ewreg   <= 1'b0;
         em2reg  <= 1'b0;
         ewmem   <= 1'b0;
         ejal    <= 1'b0;
         ealuimm <= 1'b0;
         eshift  <= 1'b0;
         ealuc   <= '0;
         ea      <= 32'h0000_0000;
         eb      <= 32'h0000_0000;
         eimm    <= 32'h0000_0000;
         epc4    <= 32'h0000_0000;
         ern0    <= 5'd0;
         evalid  <= 1'b0;
         nbubble <= '0;
      end else if (!hold) begin
         ewreg   <= dwreg  & ~bubble_s;
         em2reg  <= dm2reg & ~bubble_s;
         ewmem   <= dwmem  & ~bubble_s;
         ejal    <= djal   & ~bubble_s;
         evalid  <= ~bubble_s;
         ealuimm <= daluimm;
         eshift  <= dshift;
         ealuc   <= daluc;
         ea      <= fwd_a_s;
         eb      <= fwd_b_s;
         eimm    <= dimm;
         epc4    <= dpc4;
         ern0    <= drn;
         if (bubble_s) begin
            nbubble <= nbubble + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_pipe_idexe_reg.sv
// Directed self-checking bench for pipe_idexe_reg.
module tb_pipe_idexe_reg;

   logic        clock = 1'b0;
   logic        resetn;
   logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift;
   logic [3:0]  daluc;
   logic [31:0] da, db, dimm, dpc4;
   logic [4:0]  drs, drt, drn;
   logic        dusers, duserts, dflush, hold;
   logic [4:0]  ern, mrn;
   logic [31:0] ealu, malu, mmo;
   logic        mwreg, mm2reg;
   logic        ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
   logic [3:0]  ealuc;
   logic [31:0] ea, eb, eimm, epc4;
   logic [4:0]  ern0;
   logic        evalid, stall;
   logic [15:0] nbubble;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_nb = 16'd0;

   always #5 clock = ~clock;

   pipe_idexe_reg #(.CNTW(16)) dut (
      .clock(clock), .resetn(resetn),
      .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
      .daluimm(daluimm), .dshift(dshift), .daluc(daluc),
      .da(da), .db(db), .dimm(dimm), .dpc4(dpc4),
      .drs(drs), .drt(drt), .drn(drn), .dusers(dusers), .duserts(duserts),
      .dflush(dflush), .hold(hold),
      .ern(ern), .ealu(ealu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
      .malu(malu), .mmo(mmo),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
      .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc),
      .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
      .evalid(evalid), .stall(stall), .nbubble(nbubble)
   );

   task tick;
      @(posedge clock);
      #1;
   endtask

   task clear_hazards;
      ern = 5'd0; ealu = 32'd0; mrn = 5'd0; mwreg = 1'b0; mm2reg = 1'b0;
      malu = 32'd0; mmo = 32'd0; dflush = 1'b0; hold = 1'b0;
      // EXE-stage controls are DUT outputs; hazards on them come from loaded instructions
   endtask

   task test_reset;
      resetn = 1'b0;
      dwreg = 1'b0; dm2reg = 1'b0; dwmem = 1'b0; djal = 1'b0; daluimm = 1'b0; dshift = 1'b0;
      daluc = 4'd0; da = 32'd0; db = 32'd0; dimm = 32'd0; dpc4 = 32'd0;
      drs = 5'd0; drt = 5'd0; drn = 5'd0; dusers = 1'b0; duserts = 1'b0;
      clear_hazards();
      #3;
      n_checks++; if ({ewreg, em2reg, ewmem, ejal, ealuimm, eshift} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 000000", {ewreg, em2reg, ewmem, ejal, ealuimm, eshift}); end
      n_checks++; if ({ea, eb, eimm, epc4} !== 128'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {ea, eb, eimm, epc4}); end
      n_checks++; if (evalid !== 1'b0) begin n_fail++; $display("FAIL reset_evalid got %b exp 0", evalid); end
      n_checks++; if (nbubble !== 16'd0) begin n_fail++; $display("FAIL reset_nbubble got %h exp 0", nbubble); end
      tick(); tick();
      resetn = 1'b1;
   endtask

   // E-stage ALU result forwarded to a consumer of $3.
   task test_exe_fwd;
      // put a non-load writer of $3 into E (ewreg=1, em2reg=0)
      dwreg = 1'b1; dm2reg = 1'b0; drn = 5'd3; daluc = 4'd2; dimm = 32'h44; dpc4 = 32'h104;
      tick();
      ern = 5'd3; ealu = 32'h10;
      drs = 5'd3; dusers = 1'b1; da = 32'h99; drn = 5'd7;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exe_fwd_stall got %b exp 0", stall); end
      tick();
      n_checks++; if (ea !== 32'h10) begin n_fail++; $display("FAIL exe_fwd_ea got %h exp 00000010", ea); end
      n_checks++; if ({ewreg, evalid, ern0} !== {1'b1, 1'b1, 5'd7}) begin n_fail++; $display("FAIL exe_fwd_ctrl got %b/%b/%0d exp 1/1/7", ewreg, evalid, ern0); end
      n_checks++; if ({ealuc, eimm, epc4} !== {4'd2, 32'h44, 32'h104}) begin n_fail++; $display("FAIL exe_fwd_fields got %h/%h/%h exp 2/44/104", ealuc, eimm, epc4); end
   endtask

   // EXE beats MEM; MEM picks malu or mmo by mm2reg.
   task test_mem_priority;
      drn = 5'd5; tick();              // E now writes $5
      ern = 5'd5; ealu = 32'd1; mwreg = 1'b1; mrn = 5'd5; malu = 32'd2; mmo = 32'd7;
      drs = 5'd5; drt = 5'd5; dusers = 1'b1; duserts = 1'b1; da = 32'h99; db = 32'h55;
      dwreg = 1'b0; tick();            // consumer loads; E no longer writes
      n_checks++; if ({ea, eb} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL mem_prio_exe got %h/%h exp 1/1", ea, eb); end
      tick();
      n_checks++; if ({ea, eb} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL mem_prio_malu got %h/%h exp 2/2", ea, eb); end
      mm2reg = 1'b1; tick();
      n_checks++; if ({ea, eb} !== {32'd7, 32'd7}) begin n_fail++; $display("FAIL mem_prio_mmo got %h/%h exp 7/7", ea, eb); end
      mwreg = 1'b0; mm2reg = 1'b0; tick();
      n_checks++; if ({ea, eb} !== {32'h99, 32'h55}) begin n_fail++; $display("FAIL mem_prio_rf got %h/%h exp 99/55", ea, eb); end
   endtask

   // lw $4 in E, add reads $4 via rt: one bubble, then mmo forwarded.
   task test_load_use;
      dwreg = 1'b1; dm2reg = 1'b1; drn = 5'd4; dusers = 1'b0; duserts = 1'b0; tick();
      ern = 5'd4; ealu = 32'hBAD;
      dm2reg = 1'b0; drn = 5'd6; drs = 5'd1; drt = 5'd4; dusers = 1'b1; duserts = 1'b1;
      da = 32'hA; db = 32'hB;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL luse_stall got %b exp 1", stall); end
      tick();
      exp_nb = exp_nb + 16'd1;
      n_checks++; if ({ewreg, evalid} !== 2'b00) begin n_fail++; $display("FAIL luse_bubble got %b%b exp 00", ewreg, evalid); end
      n_checks++; if (nbubble !== exp_nb) begin n_fail++; $display("FAIL luse_nbubble got %h exp %h", nbubble, exp_nb); end
      ern = 5'd0; mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd4; mmo = 32'h1234;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL luse_stall_drop got %b exp 0", stall); end
      tick();
      n_checks++; if ({eb, ea, evalid} !== {32'h1234, 32'hA, 1'b1}) begin n_fail++; $display("FAIL luse_after got %h/%h/%b exp 1234/a/1", eb, ea, evalid); end
      mwreg = 1'b0; mm2reg = 1'b0;
   endtask

   // $0 never forwards; jal link value forwards from ern=31.
   task test_zero_jal;
      drn = 5'd0; tick();              // E writes $0
      ern = 5'd0; ealu = 32'hFF; drs = 5'd0; da = 32'h5; drn = 5'd31; djal = 1'b1;
      tick();
      n_checks++; if (ea !== 32'h5) begin n_fail++; $display("FAIL zero_nofwd got %h exp 5", ea); end
      n_checks++; if (ejal !== 1'b1) begin n_fail++; $display("FAIL jal_ejal got %b exp 1", ejal); end
      djal = 1'b0; ern = 5'd31; ealu = 32'h108; drs = 5'd31; da = 32'h0;
      tick();
      n_checks++; if (ea !== 32'h108) begin n_fail++; $display("FAIL jal_fwd got %h exp 108", ea); end
   endtask

   // hold with luse freezes E and counter; dflush bubbles counted once.
   task test_hold_flush;
      dwreg = 1'b1; dm2reg = 1'b1; drn = 5'd4; tick();    // load into E
      n_checks++; if ({ewreg, em2reg} !== 2'b11) begin n_fail++; $display("FAIL hold_setup got %b%b exp 11", ewreg, em2reg); end
      ern = 5'd4; drt = 5'd4; duserts = 1'b1; dm2reg = 1'b0; drn = 5'd9; da = 32'hDEAD;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall got %b exp 1", stall); end
         tick();
         n_checks++; if ({ern0, em2reg, evalid, nbubble} !== {5'd4, 1'b1, 1'b1, exp_nb}) begin n_fail++; $display("FAIL hold_frozen got %0d/%b/%b/%h exp 4/1/1/%h", ern0, em2reg, evalid, nbubble, exp_nb); end
      end
      hold = 1'b0;
      dflush = 1'b1; dwmem = 1'b1;     // flush coincides with luse
      tick();
      exp_nb = exp_nb + 16'd1;
      n_checks++; if ({ewreg, ewmem, evalid, nbubble} !== {1'b0, 1'b0, 1'b0, exp_nb}) begin n_fail++; $display("FAIL flush_luse got %b/%b/%b/%h exp 0/0/0/%h", ewreg, ewmem, evalid, nbubble, exp_nb); end
      duserts = 1'b0; tick();          // E is a bubble now: flush alone
      exp_nb = exp_nb + 16'd1;
      n_checks++; if ({ewmem, evalid, nbubble} !== {1'b0, 1'b0, exp_nb}) begin n_fail++; $display("FAIL flush_only got %b/%b/%h exp 0/0/%h", ewmem, evalid, nbubble, exp_nb); end
      dflush = 1'b0; dwmem = 1'b0; tick();
      n_checks++; if ({ewreg, evalid} !== 2'b11) begin n_fail++; $display("FAIL flush_recover got %b%b exp 11", ewreg, evalid); end
   endtask

   task test_reset_midstall;
      da = 32'h3C; drs = 5'd2; dusers = 1'b0; tick();
      hold = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if ({ewreg, evalid, ea, nbubble} !== {1'b0, 1'b0, 32'd0, 16'd0}) begin n_fail++; $display("FAIL reset_async got %b/%b/%h/%h exp 0/0/0/0", ewreg, evalid, ea, nbubble); end
      tick();
      resetn = 1'b1; hold = 1'b0; da = 32'h77;
      tick();
      n_checks++; if ({ewreg, evalid, ea, nbubble} !== {1'b1, 1'b1, 32'h77, 16'd0}) begin n_fail++; $display("FAIL reset_first got %b/%b/%h/%h exp 1/1/77/0", ewreg, evalid, ea, nbubble); end
   endtask

   task test_wrap;
      dflush = 1'b1;
      repeat (65535) tick();
      n_checks++; if (nbubble !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h exp ffff", nbubble); end
      tick();
      n_checks++; if (nbubble !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", nbubble); end
      dflush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_exe_fwd();
      test_mem_priority();
      test_load_use();
      test_zero_jal();
      test_hold_flush();
      test_reset_midstall();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_idexe_reg.md
# pipe_idexe_reg

ID/EXE boundary block for the 5-stage pipelined MIPS core. It is the producer side of the EXE-stage operand/control interface. It resolves operand forwarding from the EXE and MEM stages and detects load-use hazards. It registers the decoded instruction into the E-stage signals that drive the ALU, the immediate/shift muxes and the jal link logic. It inserts bubbles on interlock or flush, holds on a downstream stall, and keeps a bubble counter for performance debug.

## Interface
Parameters:
- CNTW, 16, width of the bubble counter

Ports:
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- dwreg, dm2reg, dwmem, djal, daluimm, dshift  in  1 each  decoded ID-stage controls
- daluc  in  4  ALU operation code
- da, db, dimm, dpc4  in  32 each  register-file A/B values, extended immediate, PC+4
- drs, drt, drn  in  5 each  source registers; destination register before the jal override
- dusers, duserts  in  1 each  instruction reads rs / rt
- dflush  in  1  kill the ID instruction (exception/redirect)
- hold  in  1  downstream stall: freeze the E registers
- ern  in  5  final EXE destination, after the jal override to 31
- ealu  in  32  EXE result
- mrn  in  5  MEM destination register
- mwreg, mm2reg  in  1 each  MEM-stage controls
- malu, mmo  in  32 each  MEM ALU result and memory load data
- ewreg, em2reg, ewmem, ejal, ealuimm, eshift  out  1 each  registered controls
- ealuc  out  4  registered ALU code
- ea, eb, eimm, epc4  out  32 each  registered operands
- ern0  out  5  registered destination
- evalid  out  1  E-stage slot holds a real instruction
- stall  out  1  freeze PC and IF/ID (the wpcir inverse)
- nbubble  out  CNTW  bubbles inserted since reset

## Operation
- **Forward A (same rules for B, using drt/duserts):**
  - EXE match: ewreg & ~em2reg & ern≠0 & ern==drs selects ealu.
  - Otherwise MEM match: mwreg & mrn≠0 & mrn==drs selects mmo if mm2reg, else malu.
  - Otherwise selects da. EXE has priority over MEM.
- **Register 0:** never forwarded and never causes an interlock.
- **Load-use interlock:** luse = ewreg & em2reg & ern≠0 & ((dusers & ern==drs) | (duserts & ern==drt)).
- **Stall output:** stall = hold | luse.
- **E-register update priority per clock edge:** reset > hold > (dflush | luse) > load.
  - hold: every E register keeps its value; the counter is unchanged.
  - bubble (dflush or luse): ewreg, ewmem, em2reg, ejal and evalid load 0. Data fields load their D values. nbubble increments, wrapping modulo 2^CNTW.
  - load: every E field loads its forwarded or D value; evalid=1.
- **jal:** needs no special case. Its link value reaches ealu with ern=31 and forwards normally.

## Timing
- Reset (async assert, sync release): all registered outputs are 0, including evalid and nbubble.
- Latency: 1 cycle from D inputs to E outputs.
- Forwarding and luse are combinational within the D cycle.
- stall is combinational and valid in the same cycle as its cause.
- A load-use hazard always costs exactly 1 bubble. In the following cycle the load is in MEM, and mm2reg forwarding supplies mmo.
- hold together with luse: the E registers hold, stall=1, and no bubble is counted. luse is re-evaluated after hold drops.
- dflush together with luse: a single bubble, counted once.
- Reset asserted mid-stall: outputs clear immediately. The first post-reset instruction loads normally.

## Structure
- **Shared package pipe_pkg:**
  - ALUC_W=4
  - forward-select encodings FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MALU=2'b10, FWD_MMO=2'b11
  - REG_ZERO=5'd0, REG_RA=5'd31
- **Sub-module fwd_sel:** instantiated twice (A, B). Inputs are the source register and the E/M hazard inputs. It outputs the 2-bit select and the 32-bit operand.
- **Top level:** holds the luse logic, the registers and the counter.

## Test plan
- **EXE forward:** add $3 in E (ealu=0x10); D reads rs=$3, da=0x99 -> next cycle ea=0x10, stall never 1.
- **MEM priority:** E and M both write $5 (ealu=1, malu=2) -> ea=1. With E not writing -> ea=2. With mm2reg=1, mmo=7 -> ea=7.
- **Load-use:** lw $4 in E; D is add reading rt=$4 -> stall=1 for 1 cycle, ewreg=0/evalid=0 bubble, nbubble=1. Next cycle eb=mmo.
- **$0 and jal:** E writes $0 with ealu=0xFF -> not forwarded. E is jal (ern=31, ealu=pc4+4=0x108), D reads $31 -> ea=0x108.
- **hold+luse, dflush:** hold=1 with luse for 3 cycles -> E outputs frozen, nbubble unchanged. dflush -> ewmem=0, evalid=0, nbubble+1.
- **Reset mid-stall and counter wrap:** resetn low during stall -> all outputs 0 asynchronously. Counter at 0xFFFF plus one bubble -> 0x0000.
